// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus bundle: execute redirect, instruction-memory port, and the
// decode-facing output buffer, plus the FSM state for observation.
//
// Handshakes (both are plain valid/ready): a memory address transfers on a
// rising edge where imem_req & imem_ack; the held instruction transfers to
// decode on a rising edge where out_valid & out_ready. imem_rvalid has no
// ready: the fetch unit always accepts returned data in the cycle it is shown.
interface if_fetch_unit_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [1:0]  state_dbg;

  // Fetch-unit side
  modport master (
    input  redirect, redirect_pc, imem_ack, imem_rvalid, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_pc, out_inst, state_dbg
  );

  // Environment side: execute stage, instruction memory and decode
  modport slave (
    output redirect, redirect_pc, imem_ack, imem_rvalid, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_pc, out_inst, state_dbg
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: keeps one memory request in flight at most, holds
// the returned word in a single output buffer for decode, and follows
// redirects from execute, discarding any data that belongs to the old path.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  if_fetch_unit_if.master bus
);

  localparam logic [1:0] S_ADDR = 2'd0;  // issue address
  localparam logic [1:0] S_WAIT = 2'd1;  // one request outstanding
  localparam logic [1:0] S_DROP = 2'd2;  // outstanding request to be discarded

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        out_valid_q;
  logic [31:0] out_pc_q;
  logic [31:0] out_inst_q;

  logic        req;
  logic        accept;
  logic        load;
  logic        buf_free;

  // The buffer can take new data if empty or being drained this cycle, so an
  // address is only issued when the returning word is guaranteed a slot.
  assign buf_free = !out_valid_q || bus.out_ready;
  assign accept   = req && bus.imem_ack;
  // Returned data is kept only in WAIT and only if not overtaken by a redirect.
  assign load     = (state == S_WAIT) && bus.imem_rvalid && !bus.redirect;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ADDR;
    else     state <= state_nxt;
  end

  // Next-state: rvalid ends any wait; a redirect with no data yet means the
  // outstanding request must still be absorbed in DROP.
  always_comb begin
    state_nxt = state;
    case (state)
      S_ADDR: if (accept) state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.imem_rvalid)   state_nxt = S_ADDR;
        else if (bus.redirect) state_nxt = S_DROP;
      end
      S_DROP: if (bus.imem_rvalid) state_nxt = S_ADDR;
      default: state_nxt = S_ADDR;
    endcase
  end

  // FSM outputs: request only in ADDR, never during redirect or reset
  always_comb begin
    req = (state == S_ADDR) && buf_free && !bus.redirect && !rst;
  end

  // Fetch address bookkeeping: issued address and next sequential pc
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      pend_pc <= 32'h0000_0000;
    end else begin
      if (accept) pend_pc <= pc;
      if (bus.redirect)  pc <= bus.redirect_pc & 32'hFFFF_FFFC;
      else if (load)     pc <= pend_pc + 32'd4;  // wraps modulo 2^32
    end
  end

  // Output buffer towards decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= 32'h0000_0000;
      out_inst_q  <= 32'h0000_0000;
    end else begin
      if (bus.redirect) begin
        out_valid_q <= 1'b0;
      end else if (load) begin
        out_valid_q <= 1'b1;
        out_pc_q    <= pend_pc;
        out_inst_q  <= bus.imem_rdata;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a behavioural instruction memory with adjustable
// ack/rvalid latency, a directed stimulus sequence, and a monitor that checks
// every address handshake and every decode transfer against expected queues.
module tb_if_fetch_unit;

  localparam logic [1:0] ST_ADDR = 2'd0;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic clk;
  logic rst;

  if_fetch_unit_if fbus ();

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fbus)
  );

  // Scoreboard state
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_out_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  // Memory knobs
  logic ack_en;
  int   ack_delay;
  int   rv_delay;

  // Monitor bookkeeping
  int cyc = 0;
  int acc_count = 0;
  int acc_cyc = 0;
  int acc_gap = 0;
  logic        p_req_wait = 1'b0;
  logic [31:0] p_addr = 32'h0;
  logic        p_hold = 1'b0;
  logic [31:0] p_pc = 32'h0;
  logic [31:0] p_inst = 32'h0;
  logic        p_redir = 1'b0;

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0000_0000) return 32'h2000_0001;
    return addr ^ 32'hC3C3_0000;
  endfunction

  // Behavioural memory: runs 2 time units after each negedge, after the
  // driver has updated inputs and the DUT's request has settled.
  initial begin
    logic        pend;
    logic [31:0] pend_addr;
    int          rv_cnt;
    int          wait_cnt;
    pend = 1'b0; pend_addr = 32'h0; rv_cnt = 0; wait_cnt = 0;
    fbus.imem_ack = 1'b0; fbus.imem_rvalid = 1'b0; fbus.imem_rdata = 32'h0;
    forever begin
      @(negedge clk); #2;
      fbus.imem_rvalid = 1'b0;
      if (pend) begin
        rv_cnt--;
        if (rv_cnt <= 0) begin
          fbus.imem_rvalid = 1'b1;
          fbus.imem_rdata  = mem_word(pend_addr);
          pend = 1'b0;
        end
      end
      fbus.imem_ack = ack_en && fbus.imem_req && (wait_cnt >= ack_delay);
      if (fbus.imem_ack) begin
        pend = 1'b1; pend_addr = fbus.imem_addr; rv_cnt = rv_delay; wait_cnt = 0;
      end else if (fbus.imem_req && ack_en) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: samples 1 time unit before each rising edge
  initial begin
    forever begin
      @(negedge clk); #4;
      cyc++;
      if (rst) begin
        p_req_wait = 1'b0; p_hold = 1'b0; p_redir = 1'b0;
      end else begin
        if (p_req_wait && !fbus.redirect) begin
          chk("req_held", 64'(fbus.imem_req), 64'd1);
          chk("addr_held", 64'(fbus.imem_addr), 64'(p_addr));
        end
        if (p_hold && !p_redir) begin
          chk("out_hold_valid", 64'(fbus.out_valid), 64'd1);
          chk("out_hold_data", {fbus.out_pc, fbus.out_inst}, {p_pc, p_inst});
        end
        if (fbus.out_valid && !fbus.out_ready)
          chk("issue_backpressure", 64'(fbus.imem_req), 64'd0);
        if (fbus.imem_req && fbus.imem_ack) begin
          if (exp_addr_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_fetch: got addr %h required no request", fbus.imem_addr);
          end else begin
            chk("imem_addr", 64'(fbus.imem_addr), 64'(exp_addr_q.pop_front()));
          end
          acc_count++;
          acc_gap = cyc - acc_cyc;
          acc_cyc = cyc;
        end
        if (fbus.out_valid && fbus.out_ready) begin
          if (exp_out_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_output: got pc %h inst %h required no transfer",
                     fbus.out_pc, fbus.out_inst);
          end else begin
            chk("out_pc_inst", {fbus.out_pc, fbus.out_inst}, exp_out_q.pop_front());
          end
        end
        p_req_wait = fbus.imem_req && !fbus.imem_ack;
        p_addr     = fbus.imem_addr;
        p_hold     = fbus.out_valid && !fbus.out_ready;
        p_pc       = fbus.out_pc;
        p_inst     = fbus.out_inst;
        p_redir    = fbus.redirect;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for n more address handshakes; returns at a negedge
  task automatic wait_acc(input int n);
    int tgt;
    int k;
    tgt = acc_count + n;
    k = 0;
    while (acc_count < tgt && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (acc_count < tgt) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: got %0d handshakes required %0d", acc_count, tgt);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] addr, input logic keep_out);
    exp_addr_q.push_back(addr);
    if (keep_out) exp_out_q.push_back({addr, mem_word(addr)});
  endtask

  // Directed stimulus
  initial begin
    int k;
    rst = 1'b1;
    fbus.redirect = 1'b0; fbus.redirect_pc = 32'h0; fbus.out_ready = 1'b1;
    ack_en = 1'b0; ack_delay = 0; rv_delay = 1;
    cycles(2);

    // Reset state
    chk("rst_out_valid", 64'(fbus.out_valid), 64'd0);
    chk("rst_out_pc", 64'(fbus.out_pc), 64'd0);
    chk("rst_out_inst", 64'(fbus.out_inst), 64'd0);
    chk("rst_imem_req", 64'(fbus.imem_req), 64'd0);
    chk("rst_state", 64'(fbus.state_dbg), 64'(ST_ADDR));

    // Zero-wait streaming from reset, first word 0x2000_0001 at pc 0
    exp_addr_q.push_back(32'h0000_0000);
    exp_out_q.push_back({32'h0000_0000, 32'h2000_0001});
    expect_fetch(32'h0000_0004, 1'b1);
    expect_fetch(32'h0000_0008, 1'b1);
    ack_en = 1'b1;
    rst = 1'b0;
    wait_acc(3);
    ack_en = 1'b0;
    chk("throughput_gap", 64'(acc_gap), 64'd2);
    cycles(4);
    chk("drain_stream", 64'(exp_out_q.size()), 64'd0);

    // Decode back-pressure: word held, no issue, then request on release
    fbus.out_ready = 1'b0;
    expect_fetch(32'h0000_000C, 1'b1);
    ack_en = 1'b1;
    wait_acc(1);
    ack_en = 1'b0;
    k = 0;
    while (!fbus.out_valid && k < 20) begin @(negedge clk); k++; end
    chk("bp_out_valid", 64'(fbus.out_valid), 64'd1);
    cycles(4);
    fbus.out_ready = 1'b1;
    #4;
    chk("bp_release_req", {31'd0, fbus.imem_req, fbus.imem_addr}, {31'd0, 1'b1, 32'h0000_0010});
    cycles(2);

    // Ack delayed three cycles: request and address must hold meanwhile
    ack_delay = 3;
    expect_fetch(32'h0000_0010, 1'b1);
    ack_en = 1'b1;
    wait_acc(1);
    ack_en = 1'b0;
    ack_delay = 0;
    cycles(3);

    // Redirect while WAIT: old word dropped, fetch resumes at 0x100
    rv_delay = 3;
    expect_fetch(32'h0000_0014, 1'b0);
    ack_en = 1'b1;
    wait_acc(1);
    ack_en = 1'b0;
    fbus.redirect = 1'b1; fbus.redirect_pc = 32'h0000_0103;
    @(negedge clk);
    fbus.redirect = 1'b0;
    chk("redir_wait_state", 64'(fbus.state_dbg), 64'(ST_DROP));
    cycles(3);
    chk("redir_wait_next", {31'd0, fbus.imem_req, fbus.imem_addr}, {31'd0, 1'b1, 32'h0000_0100});
    chk("redir_wait_no_out", 64'(fbus.out_valid), 64'd0);
    rv_delay = 1;
    expect_fetch(32'h0000_0100, 1'b1);
    ack_en = 1'b1;
    wait_acc(1);
    ack_en = 1'b0;
    cycles(3);

    // Redirect in ADDR: no request that cycle, aligned target next cycle
    fbus.redirect = 1'b1; fbus.redirect_pc = 32'hFFFF_FFFE;
    #4;
    chk("redir_addr_req", 64'(fbus.imem_req), 64'd0);
    @(negedge clk);
    fbus.redirect = 1'b0;
    #4;
    chk("redir_addr_next", {31'd0, fbus.imem_req, fbus.imem_addr}, {31'd0, 1'b1, 32'hFFFF_FFFC});
    @(negedge clk);

    // pc wrap: 0xFFFF_FFFC followed by 0x0000_0000
    expect_fetch(32'hFFFF_FFFC, 1'b1);
    exp_addr_q.push_back(32'h0000_0000);
    exp_out_q.push_back({32'h0000_0000, 32'h2000_0001});
    ack_en = 1'b1;
    wait_acc(2);
    ack_en = 1'b0;
    cycles(3);

    // Redirect coincident with rvalid in WAIT: data dropped, straight to ADDR
    rv_delay = 2;
    expect_fetch(32'h0000_0004, 1'b0);
    ack_en = 1'b1;
    wait_acc(1);
    ack_en = 1'b0;
    @(negedge clk);
    fbus.redirect = 1'b1; fbus.redirect_pc = 32'h0000_0040;
    @(negedge clk);
    fbus.redirect = 1'b0;
    chk("redir_rv_state", 64'(fbus.state_dbg), 64'(ST_ADDR));
    #4;
    chk("redir_rv_next", {31'd0, fbus.imem_req, fbus.imem_addr}, {31'd0, 1'b1, 32'h0000_0040});
    @(negedge clk);

    // Redirects held through DROP until rvalid: last target wins
    rv_delay = 3;
    expect_fetch(32'h0000_0040, 1'b0);
    ack_en = 1'b1;
    wait_acc(1);
    ack_en = 1'b0;
    fbus.redirect = 1'b1; fbus.redirect_pc = 32'h0000_0080;
    @(negedge clk);
    fbus.redirect_pc = 32'h0000_0200;
    @(negedge clk);
    fbus.redirect_pc = 32'h0000_0300;
    @(negedge clk);
    fbus.redirect = 1'b0;
    chk("drop_rv_state", 64'(fbus.state_dbg), 64'(ST_ADDR));
    #4;
    chk("drop_rv_next", {31'd0, fbus.imem_req, fbus.imem_addr}, {31'd0, 1'b1, 32'h0000_0300});
    chk("drop_rv_no_out", 64'(fbus.out_valid), 64'd0);
    @(negedge clk);

    // Reset while WAIT, late rvalid afterwards must be ignored
    rv_delay = 4;
    expect_fetch(32'h0000_0300, 1'b0);
    ack_en = 1'b1;
    wait_acc(1);
    ack_en = 1'b0;
    rst = 1'b1;
    #4;
    chk("rst_mid_req", 64'(fbus.imem_req), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #4;
    chk("rst_first_addr", {31'd0, fbus.imem_req, fbus.imem_addr}, {31'd0, 1'b1, 32'h0000_0000});
    k = 0;
    @(negedge clk);
    while (!fbus.imem_rvalid && k < 10) begin @(negedge clk); k++; end
    chk("late_rvalid_seen", 64'(fbus.imem_rvalid), 64'd1);
    @(negedge clk);
    chk("late_rvalid_out", 64'(fbus.out_valid), 64'd0);
    chk("late_rvalid_state", 64'(fbus.state_dbg), 64'(ST_ADDR));
    chk("late_rvalid_addr", 64'(fbus.imem_addr), 64'd0);
    rv_delay = 1;
    exp_addr_q.push_back(32'h0000_0000);
    exp_out_q.push_back({32'h0000_0000, 32'h2000_0001});
    ack_en = 1'b1;
    wait_acc(1);
    ack_en = 1'b0;
    cycles(4);

    // Every expected response must have been observed
    chk("addr_queue_empty", 64'(exp_addr_q.size()), 64'd0);
    chk("out_queue_empty", 64'(exp_out_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port redirect  input  1  branch/jump taken from execute; highest priority.
REQ-005 The block SHALL have port redirect_pc  input  32  target address, valid when redirect=1.
REQ-006 The block SHALL have port imem_req  output  1  address-phase valid to instruction memory.
REQ-007 The block SHALL have port imem_addr  output  32  fetch address, valid when imem_req=1.
REQ-008 The block SHALL have port imem_ack  input  1  address accepted when imem_req&imem_ack.
REQ-009 The block SHALL have port imem_rvalid  input  1  read data returned, 1 or more cycles after ack.
REQ-010 The block SHALL have port imem_rdata  input  32  instruction word, valid when imem_rvalid=1.
REQ-011 The block SHALL have port out_valid  output  1  fetched instruction held for decode.
REQ-012 The block SHALL have port out_ready  input  1  decode accepts; transfer when out_valid&out_ready.
REQ-013 The block SHALL have port out_pc  output  32  address of held instruction.
REQ-014 The block SHALL have port out_inst  output  32  held instruction word.

Function
REQ-015 The block SHALL implement FSM states ADDR (issue address), WAIT (one request outstanding), DROP (outstanding request to be discarded).
REQ-016 The block SHALL keep at most one memory request outstanding; imem_rvalid outside WAIT/DROP SHALL be ignored.
REQ-017 In ADDR, imem_req SHALL equal (!out_valid | out_ready) & !redirect; imem_addr SHALL equal the internal pc register.
REQ-018 ADDR -> WAIT on imem_req&imem_ack; the issued address SHALL be latched as the pending pc.
REQ-019 WAIT on imem_rvalid (no redirect): out_valid<=1, out_inst<=imem_rdata, out_pc<=pending pc, pc<=pending pc+4, -> ADDR.
REQ-020 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-021 out_valid SHALL clear on out_valid&out_ready unless reloaded the same cycle per REQ-019; out_pc/out_inst SHALL hold while out_valid&!out_ready.
REQ-022 Redirect SHALL act in any state: pc<={redirect_pc[31:2],2'b00}, out_valid<=0.
REQ-023 Redirect in WAIT, or in DROP: next state DROP; redirect in WAIT coincident with imem_rvalid: data discarded, next state ADDR.
REQ-024 Redirect in ADDR: next state ADDR, imem_req=0 that cycle, new pc requested next cycle.
REQ-025 DROP on imem_rvalid: data discarded, out_valid unchanged, -> ADDR (or DROP stays if redirect also, then ADDR per REQ-023 rule: rvalid wins, -> ADDR with new pc).
REQ-026 Issue back-pressure: no address SHALL be issued while out_valid&!out_ready, so the output buffer is always free when data returns.
REQ-027 Throughput SHALL be one instruction per 2 cycles with zero-wait memory (ack same cycle as req, rvalid next cycle).

Reset
REQ-028 On rst: state=ADDR, pc=RESET_PC, out_valid=0, out_pc=0, out_inst=0, pending pc=0; imem_req SHALL be 0 while rst=1.
REQ-029 Reset asserted mid-request SHALL abandon the outstanding request; a late imem_rvalid after release SHALL be ignored (state ADDR).

Verification
REQ-030 Reset release, ack immediate, rvalid next cycle, data 32'h2000_0001, out_ready=1 -> imem_addr 0x0 then 0x4; out_pc=0x0, out_inst=32'h2000_0001 for one cycle.
REQ-031 out_ready=0 with out_valid=1 -> imem_req stays 0, out_pc/out_inst stable; out_ready=1 -> req for next pc in same cycle.
REQ-032 Redirect to 32'h0000_0103 while WAIT -> returned data discarded, next imem_addr=32'h0000_0100, out_valid never shows the dropped word.
REQ-033 imem_ack delayed 3 cycles -> imem_req and imem_addr held constant all 3 cycles.
REQ-034 pc=32'hFFFF_FFFC fetch completes -> next imem_addr=32'h0000_0000.
REQ-035 rst pulse while WAIT, rvalid arrives after release -> ignored; first post-reset imem_addr=RESET_PC, out_valid=0.
